padring_cfg_ctrl: RTL
=====================

Name: padring_cfg_ctrl

Overview:
- Configuration and power-up sequencer for the four core-side pad groups: we, no, so, ea; 9 pins each, 16-bit tech_cfg per pin.
- Holds double-buffered per-pin config (ie, output enable, tech_cfg) written over a simple register port.
- Commits the config atomically and releases pad sides one at a time, with a settle gap between sides, to limit simultaneous switching.
- Drives the ie/oen/tech_cfg pins of asic_core.

Parameters:
- NPINS, 9: pins per side; addressable pin indices are 0..NPINS-1.
- CFGW, 16: tech_cfg bits per pin.
- SETTLE, 16: cycles between consecutive side releases; must be >= 1.

Ports:
- clk  in  1  sole clock.
- nreset  in  1  asynchronous active-low reset.
- reg_valid  in  1  request strobe; accepted every cycle (no backpressure).
- reg_write  in  1  1=write, 0=read.
- reg_addr  in  8  register address.
- reg_wdata  in  32  write data.
- reg_rvalid  out  1  read data valid, exactly 1 cycle after an accepted read.
- reg_rdata  out  32  read data; 0 when reg_rvalid=0.
- we_ie / no_ie / so_ie / ea_ie  out  NPINS each  input enable per pin.
- we_oen / no_oen / so_oen / ea_oen  out  NPINS each  output enable per pin, active-low.
- we_tech_cfg / no_tech_cfg / so_tech_cfg / ea_tech_cfg  out  NPINS*CFGW each  per-pin tech config; pin i is at bits [i*CFGW +: CFGW].

Behaviour:
- Clocking and reset:
  - One clock (clk).
  - Reset is asynchronous and active-low (nreset).
  - On reset: shadow and active config = 0, state = QUIET, counter = 0, reg_rvalid = 0, reg_rdata = 0.
- Address map:
  - reg_addr[7]=0 selects the pin space: side = reg_addr[6:5] (0=we, 1=no, 2=so, 3=ea); pin = reg_addr[3:0].
  - reg_addr[4]=1, or pin >= NPINS, is invalid: writes are ignored and reads return 0.
- Pin word format: [15:0] tech_cfg, [16] ie, [17] oe (1=drive). Other bits are written as don't-care and read back as 0.
- Pin-space writes update the SHADOW copy only. Pin-space reads return the SHADOW value.
- 0x80 CTRL (write-only; reads return 0):
  - bit0 COMMIT: shadow->active copy of all 36 pins in one cycle; visible on outputs the cycle after the write.
  - bit1 RELEASE: start the release sequence; acted on only in state QUIET.
  - bit2 QUIESCE: all sides quiet the next cycle, state=QUIET, counter=0.
  - QUIESCE has priority over RELEASE in the same write. COMMIT in the same write still takes effect.
- 0x81 STATUS (read-only): [3:0] released mask (bit0=we, bit1=no, bit2=so, bit3=ea); [6:4] state code. Other addresses >= 0x80 read 0.
- State machine (codes): QUIET=0, REL_WE=1, REL_NO=2, REL_SO=3, REL_EA=4, RUN=5.
  - QUIET --RELEASE--> REL_WE.
  - Each REL_x state sets its side's released bit on entry.
  - Each REL_x state holds for SETTLE cycles (counter 0..SETTLE-1), then advances to the next state: REL_WE->REL_NO->REL_SO->REL_EA->RUN.
  - RUN holds until QUIESCE.
  - QUIESCE from any state returns to QUIET and clears all released bits.
- Released masks by state: QUIET=0000, REL_WE=0001, REL_NO=0011, REL_SO=0111, REL_EA=1111, RUN=1111.
- Output mapping per side:
  - Released: ie = active ie; oen = ~active oe; tech_cfg = active tech_cfg.
  - Not released: ie = 0; oen = all 1s (tristate); tech_cfg = 0.
  - Outputs are combinational from the state and active registers only; no path from reg_* to pad pins.
- Commit timing: COMMIT is allowed in any state. Mid-sequence, already-released sides switch to the new active values immediately.
- Same-cycle events:
  - A pin write and a COMMIT in the same cycle is impossible (one request per cycle).
  - A read of a pin just written returns the new shadow value.
- Reset mid-sequence returns to QUIET with all pads tristated.

Test Plan:
- Reset -> all *_oen = 0x1FF, all *_ie = 0, all tech_cfg = 0; STATUS read = 0x00 with reg_rvalid one cycle after the read.
- Write addr 0x23 (no, pin 3) = 0x3ABCD, read it back -> 0x3ABCD. Outputs remain unchanged until COMMIT and release complete; then no_oen = 0x1F7, no_ie bit3 = 1, no_tech_cfg[63:48] = 0xABCD.
- Write CTRL = 0x3 (commit+release) with SETTLE=16 -> we released 1 cycle after the write; no, so, ea released at +16, +32 and +48 cycles; STATUS reads 0x5F after the sequence.
- QUIESCE written while in REL_SO -> next cycle all oen = 0x1FF and STATUS = 0x00; a later RELEASE restarts from we.
- Write addr 0x09 (pin 9) and 0x1X (reg_addr[4]=1) -> no shadow change; reads return 0.
- CTRL = 0x6 (release+quiesce) in QUIET -> stays QUIET; nreset asserted in RUN -> pads tristated immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/padring_cfg_ctrl.sv
// Pad-ring configuration sequencer: double-buffered per-pin config and
// staged side release (we, no, so, ea) with a settle gap between sides.
module padring_cfg_ctrl #(
    parameter int NPINS  = 9,
    parameter int CFGW   = 16,
    parameter int SETTLE = 16
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  reg_valid,
    input  logic                  reg_write,
    input  logic [7:0]            reg_addr,
    input  logic [31:0]           reg_wdata,
    output logic                  reg_rvalid,
    output logic [31:0]           reg_rdata,
    output logic [NPINS-1:0]      we_ie,
    output logic [NPINS-1:0]      no_ie,
    output logic [NPINS-1:0]      so_ie,
    output logic [NPINS-1:0]      ea_ie,
    output logic [NPINS-1:0]      we_oen,
    output logic [NPINS-1:0]      no_oen,
    output logic [NPINS-1:0]      so_oen,
    output logic [NPINS-1:0]      ea_oen,
    output logic [NPINS*CFGW-1:0] we_tech_cfg,
    output logic [NPINS*CFGW-1:0] no_tech_cfg,
    output logic [NPINS*CFGW-1:0] so_tech_cfg,
    output logic [NPINS*CFGW-1:0] ea_tech_cfg
);

    typedef enum logic [2:0] {
        QUIET  = 3'd0,
        REL_WE = 3'd1,
        REL_NO = 3'd2,
        REL_SO = 3'd3,
        REL_EA = 3'd4,
        RUN    = 3'd5
    } state_t;

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef logic [NPINS-1:0][CFGW-1:0] cfg_vec_t;

    logic [3:0][NPINS-1:0] sh_ie, sh_oe, act_ie, act_oe;
    cfg_vec_t [3:0]        sh_cfg, act_cfg;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      rel_mask;

    logic [1:0]      side;
    logic [3:0]      pin;
    logic            pin_ok, pin_wr, ctrl_wr;
    logic            commit, rel_req, qui_req;
    logic [31:0]     rd;

    assign side    = reg_addr[6:5];
    assign pin     = reg_addr[3:0];
    assign pin_ok  = !reg_addr[7] && !reg_addr[4] && (int'(pin) < NPINS);
    assign pin_wr  = reg_valid && reg_write && pin_ok;
    assign ctrl_wr = reg_valid && reg_write && (reg_addr == 8'h80);
    assign commit  = ctrl_wr && reg_wdata[0];
    assign rel_req = ctrl_wr && reg_wdata[1];
    assign qui_req = ctrl_wr && reg_wdata[2];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sh_ie  <= '0;
            sh_oe  <= '0;
            sh_cfg <= '0;
        end else if (pin_wr) begin
            sh_cfg[side][pin] <= reg_wdata[CFGW-1:0];
            sh_ie[side][pin]  <= reg_wdata[16];
            sh_oe[side][pin]  <= reg_wdata[17];
        end
    end

    // All 36 pins move to the active copy together.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            act_ie  <= '0;
            act_oe  <= '0;
            act_cfg <= '0;
        end else if (commit) begin
            act_ie  <= sh_ie;
            act_oe  <= sh_oe;
            act_cfg <= sh_cfg;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= QUIET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (qui_req) begin
            state_d = QUIET;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                QUIET: begin
                    if (rel_req) begin
                        state_d = REL_WE;
                        cnt_d   = '0;
                    end
                end
                REL_WE, REL_NO, REL_SO, REL_EA: begin
                    if (cnt_q == CW'(SETTLE - 1)) begin
                        cnt_d   = '0;
                        state_d = state_t'(state_q + 3'd1);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RUN: ;
                default: begin
                    state_d = QUIET;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        rel_mask = 4'b0000;
        unique case (state_q)
            REL_WE:      rel_mask = 4'b0001;
            REL_NO:      rel_mask = 4'b0011;
            REL_SO:      rel_mask = 4'b0111;
            REL_EA, RUN: rel_mask = 4'b1111;
            default:     rel_mask = 4'b0000;
        endcase
    end

    logic [3:0][NPINS-1:0] ie_o, oen_o;
    cfg_vec_t [3:0]        cfg_o;

    // Unreleased sides are tristated with inputs gated off.
    always_comb begin
        ie_o  = '0;
        oen_o = '1;
        cfg_o = '0;
        for (int s = 0; s < 4; s++) begin
            if (rel_mask[s]) begin
                ie_o[s]  = act_ie[s];
                oen_o[s] = ~act_oe[s];
                cfg_o[s] = act_cfg[s];
            end
        end
    end

    assign we_ie       = ie_o[0];
    assign no_ie       = ie_o[1];
    assign so_ie       = ie_o[2];
    assign ea_ie       = ie_o[3];
    assign we_oen      = oen_o[0];
    assign no_oen      = oen_o[1];
    assign so_oen      = oen_o[2];
    assign ea_oen      = oen_o[3];
    assign we_tech_cfg = cfg_o[0];
    assign no_tech_cfg = cfg_o[1];
    assign so_tech_cfg = cfg_o[2];
    assign ea_tech_cfg = cfg_o[3];

    always_comb begin
        rd = '0;
        if (pin_ok) begin
            rd[CFGW-1:0] = sh_cfg[side][pin];
            rd[16]       = sh_ie[side][pin];
            rd[17]       = sh_oe[side][pin];
        end else if (reg_addr == 8'h81) begin
            rd[3:0] = rel_mask;
            rd[6:4] = state_q;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            reg_rvalid <= 1'b0;
            reg_rdata  <= '0;
        end else begin
            reg_rvalid <= reg_valid && !reg_write;
            reg_rdata  <= (reg_valid && !reg_write) ? rd : 32'h0;
        end
    end

endmodule
